// File: rtl/rv_itcm_ctrl.sv
// Instruction TCM access controller: arbitrates the single RAM read port between
// instruction fetch and data reads, forwards data writes and routes 1-cycle responses.
module rv_itcm_ctrl #(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MAX_DSTREAK = 4,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [31:0]     if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [31:0]     d_wdata,
    input  logic [3:0]      d_strb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [31:0]     d_rdata,
    output logic            d_err,
    output logic            ram_wena,
    output logic [3:0]      ram_strobe,
    output logic [AW-1:0]   ram_addra,
    output logic [31:0]     ram_dina,
    output logic            ram_renb,
    output logic [AW-1:0]   ram_addrb,
    input  logic [31:0]     ram_doutb
);

    localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIf   = 2'd1,
        OwnD    = 2'd2
    } owner_e;

    owner_e     owner_q, owner_d;
    logic [3:0] streak_q, streak_d;
    logic       if_err_q, if_err_d;
    logic       d_err_q, d_err_d;
    logic       d_wr_rsp_q, d_wr_rsp_d;

    logic [AW-1:0] if_idx, d_idx;
    logic          if_oor, d_oor;
    logic          d_rd, d_wr, wr_hit, hazard, d_rd_win, d_rd_gnt;

    assign if_idx = if_addr[AW+1:2];
    assign d_idx  = d_addr[AW+1:2];
    assign if_oor = |if_addr[XLEN-1:AW+2];
    assign d_oor  = |d_addr[XLEN-1:AW+2];

    always_comb begin
        d_rd     = d_req & ~d_we;
        d_wr     = d_req & d_we;
        wr_hit   = ~rst & d_wr & ~d_oor;
        // A fetch to the word being written this cycle would read stale data.
        hazard   = wr_hit & (if_idx == d_idx);
        d_rd_win = d_rd & ((streak_q < MaxStreak) | ~if_req);

        d_gnt    = ~rst & (d_wr | d_rd_win);
        d_rd_gnt = ~rst & d_rd_win;
        if_gnt   = ~rst & if_req & ~hazard & ~d_rd_win;

        ram_wena   = wr_hit;
        ram_strobe = wr_hit ? d_strb  : 4'b0;
        ram_addra  = wr_hit ? d_idx   : '0;
        ram_dina   = wr_hit ? d_wdata : 32'b0;

        ram_renb  = 1'b0;
        ram_addrb = '0;
        if (if_gnt && !if_oor) begin
            ram_renb  = 1'b1;
            ram_addrb = if_idx;
        end else if (d_rd_gnt && !d_oor) begin
            ram_renb  = 1'b1;
            ram_addrb = d_idx;
        end
    end

    always_comb begin
        owner_d    = OwnNone;
        if (if_gnt) begin
            owner_d = OwnIf;
        end else if (d_rd_gnt) begin
            owner_d = OwnD;
        end
        if_err_d   = if_gnt & if_oor;
        d_err_d    = d_gnt & d_oor;
        d_wr_rsp_d = d_gnt & d_we;

        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = 4'd0;
        end else if (d_rd_gnt && streak_q < MaxStreak) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OwnNone;
            streak_q   <= 4'd0;
            if_err_q   <= 1'b0;
            d_err_q    <= 1'b0;
            d_wr_rsp_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            if_err_q   <= if_err_d;
            d_err_q    <= d_err_d;
            d_wr_rsp_q <= d_wr_rsp_d;
        end
    end

    // Responses are masked while reset is held so an in-flight reply is dropped.
    always_comb begin
        if_rvalid = ~rst & (owner_q == OwnIf);
        if_err    = if_rvalid & if_err_q;
        if_rdata  = (if_rvalid && !if_err_q) ? ram_doutb : 32'b0;
        d_rvalid  = ~rst & ((owner_q == OwnD) | d_wr_rsp_q);
        d_err     = d_rvalid & d_err_q;
        d_rdata   = (!rst && owner_q == OwnD && !d_err_q) ? ram_doutb : 32'b0;
    end

endmodule

// File: tb/tb_rv_itcm_ctrl.sv
// Self-checking bench for rv_itcm_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_rv_itcm_ctrl;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned MAXS  = 4;
    localparam int unsigned AW    = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt, if_rvalid, if_err;
    logic [31:0]     if_rdata;
    logic            d_req, d_we;
    logic [XLEN-1:0] d_addr;
    logic [31:0]     d_wdata;
    logic [3:0]      d_strb;
    logic            d_gnt, d_rvalid, d_err;
    logic [31:0]     d_rdata;
    logic            ram_wena, ram_renb;
    logic [3:0]      ram_strobe;
    logic [AW-1:0]   ram_addra, ram_addrb;
    logic [31:0]     ram_dina, ram_doutb;

    always #5 clk = ~clk;

    rv_itcm_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .MAX_DSTREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_strb(d_strb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .ram_wena(ram_wena), .ram_strobe(ram_strobe), .ram_addra(ram_addra),
        .ram_dina(ram_dina), .ram_renb(ram_renb), .ram_addrb(ram_addrb),
        .ram_doutb(ram_doutb)
    );

    function automatic logic [31:0] init_word(int i);
        case (i)
            4:       return 32'h0051_3023;
            8:       return 32'h1234_5678;
            default: return (32'(i) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Behavioural dual-port RAM; contents restored on reset.
    logic [31:0] ram [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wena && ram_strobe[b]) ram[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
            if (ram_renb) ram_doutb <= ram[ram_addrb];
        end
    end

    // Reference model state.
    logic [31:0] mem_m [DEPTH];
    int          streak_m;
    int          total = 0;
    int          bad = 0;
    logic        last_ig, last_dg;
    logic        obs_ig, obs_dg, obs_ie, obs_renb;
    logic [31:0] obs_ird;
    int          dv_count;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        streak_m = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = init_word(i);
    endtask

    task automatic check_idle(string tag);
        check({tag, ".if_gnt"}, 32'(if_gnt), 0);
        check({tag, ".d_gnt"}, 32'(d_gnt), 0);
        check({tag, ".if_rvalid"}, 32'(if_rvalid), 0);
        check({tag, ".d_rvalid"}, 32'(d_rvalid), 0);
        check({tag, ".if_err"}, 32'(if_err), 0);
        check({tag, ".d_err"}, 32'(d_err), 0);
        check({tag, ".if_rdata"}, if_rdata, 0);
        check({tag, ".d_rdata"}, d_rdata, 0);
        check({tag, ".ram_wena"}, 32'(ram_wena), 0);
        check({tag, ".ram_renb"}, 32'(ram_renb), 0);
    endtask

    // One clock: check request-side outputs, advance, check responses.
    task automatic cycle();
        logic [AW-1:0] ii, di, eab;
        logic          io, dox, rd, wr_hit, hz, eig, edg, erb, eie, ede;
        logic [31:0]   eid, edd;
        #2;
        ii     = if_addr[AW+1:2];
        di     = d_addr[AW+1:2];
        io     = (if_addr >> (AW + 2)) != 0;
        dox    = (d_addr >> (AW + 2)) != 0;
        rd     = d_req && !d_we;
        wr_hit = d_req && d_we && !dox;
        hz     = if_req && wr_hit && (ii == di);
        edg    = (d_req && d_we) || (rd && (streak_m < MAXS || !if_req));
        eig    = if_req && !hz && !(rd && edg);
        erb    = (eig && !io) || (rd && edg && !dox);
        eab    = (eig && !io) ? ii : ((rd && edg && !dox) ? di : '0);
        obs_ig = if_gnt;
        obs_dg = d_gnt;
        obs_renb = ram_renb;
        check("if_gnt", 32'(if_gnt), 32'(eig));
        check("d_gnt", 32'(d_gnt), 32'(edg));
        check("ram_wena", 32'(ram_wena), 32'(wr_hit));
        check("ram_renb", 32'(ram_renb), 32'(erb));
        check("ram_addrb", 32'(ram_addrb), 32'(eab));
        if (wr_hit) begin
            check("ram_addra", 32'(ram_addra), 32'(di));
            check("ram_strobe", 32'(ram_strobe), 32'(d_strb));
            check("ram_dina", ram_dina, d_wdata);
        end
        eie = eig && io;
        eid = (eig && !io) ? mem_m[ii] : 32'b0;
        ede = edg && dox;
        edd = (edg && rd && !dox) ? mem_m[di] : 32'b0;
        if (!if_req || eig) streak_m = 0;
        else if (edg && rd && streak_m < MAXS) streak_m++;
        if (wr_hit)
            for (int b = 0; b < 4; b++)
                if (d_strb[b]) mem_m[di][8*b +: 8] = d_wdata[8*b +: 8];
        last_ig = eig;
        last_dg = edg;
        @(posedge clk);
        #1;
        obs_ird = if_rdata;
        obs_ie  = if_err;
        if (d_rvalid) dv_count++;
        check("if_rvalid", 32'(if_rvalid), 32'(eig));
        check("if_err", 32'(if_err), 32'(eie));
        check("if_rdata", if_rdata, eid);
        check("d_rvalid", 32'(d_rvalid), 32'(edg));
        check("d_err", 32'(d_err), 32'(ede));
        check("d_rdata", d_rdata, edd);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 15) != 0) a = a & 32'(4 * DEPTH - 1);
        return a;
    endfunction

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_strb = 0; dv_count = 0;
        last_ig = 0; last_dg = 0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        check_idle("reset");

        // Single uncontended fetch.
        if_req = 1; if_addr = 32'h10;
        cycle();
        check("fetch0.gnt", 32'(obs_ig), 1);
        check("fetch0.data", obs_ird, 32'h0051_3023);

        // Fetch versus continuous data reads: D,D,D,D,IF repeating.
        d_req = 1; d_we = 0; d_addr = 32'h08; if_addr = 32'h40;
        for (int i = 0; i < 15; i++) begin
            cycle();
            check("streak.pattern", 32'(obs_dg), 32'((i % 5) != 4));
            if (last_ig) if_addr = if_addr + 4;
        end
        if_req = 0; d_req = 0;
        cycle();

        // Write collides with fetch to the same word.
        if_req = 1; if_addr = 32'h20;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_strb = 4'b0011; d_wdata = 32'hAAAA_BBBB;
        cycle();
        check("hazard.block", 32'(obs_ig), 0);
        d_req = 0; d_we = 0;
        cycle();
        check("hazard.gnt", 32'(obs_ig), 1);
        check("hazard.data", obs_ird, 32'h1234_BBBB);

        // First out-of-range word.
        if_addr = 32'(4 * DEPTH);
        cycle();
        check("oor.gnt", 32'(obs_ig), 1);
        check("oor.renb", 32'(obs_renb), 0);
        check("oor.err", 32'(obs_ie), 1);
        if_req = 0;
        cycle();

        // Reset during the response cycle of a data read.
        if_req = 1; if_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h0C;
        cycle();
        rst = 1'b1; if_req = 0; d_req = 0;
        #2;
        check_idle("midrst");
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        check_idle("postrst");
        if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h04;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rst.streak", 32'(obs_dg), 32'(i != 4));
        end
        if_req = 0; d_req = 0;
        cycle();

        // Fetch idle: ten back-to-back data reads.
        dv_count = 0;
        d_req = 1; d_we = 0;
        for (int i = 0; i < 10; i++) begin
            d_addr = 32'(4 * i + 4);
            cycle();
        end
        d_req = 0;
        check("dread.count", 32'(dv_count), 10);
        cycle();

        // Randomized traffic with hold-until-granted requesters.
        for (int n = 0; n < 400; n++) begin
            if (!if_req || last_ig) begin
                if_req  = $urandom_range(0, 3) != 0;
                if_addr = rand_addr();
            end
            if (!d_req || last_dg) begin
                d_req   = $urandom_range(0, 2) != 0;
                d_we    = $urandom_range(0, 2) == 0;
                d_addr  = ($urandom_range(0, 3) == 0) ? if_addr : rand_addr();
                d_wdata = $urandom;
                d_strb  = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
